nf_i_du_pl: RTL and testbench
=============================

Name: nf_i_du_pl

Overview:
- Pipelined, parametrised successor to the combinational decode unit.
- Takes a fetched instruction and its PC over a valid/ready handshake, then:
  - decodes it with the existing nf_control_unit and nf_sign_ex;
  - reads the register file and applies EX/MEM forwarding;
  - detects load-use hazards;
  - registers everything into an ID/EX stage register.
- Branch resolution moves out of decode into EX. This block only emits branch_type_o and the operands.

Parameters:
- FWD_EN, 1, 1 = EX/MEM forwarding enabled. 0 = rs data comes straight from the register file and every RAW hazard against a valid EX/MEM writer stalls.
- ILL_CHECK, 1, 1 = flag illegal encodings on ill_o and suppress their side effects.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- instr_i  in  32  fetched instruction
- pc_i  in  32  PC of instr_i
- valid_i  in  1  instr_i/pc_i valid
- ready_o  out  1  decode can accept this cycle
- flush_i  in  1  kill input and stage register (taken branch/trap)
- ra1_o, ra2_o  out  5 each  register file read addresses (combinational from instr_i)
- rd1_i, rd2_i  in  32 each  register file read data (same cycle)
- ex_we_i, ex_load_i  in  1 each  EX stage writes rd / EX stage is a load
- ex_wa_i  in  5  EX destination
- ex_res_i  in  32  EX ALU result
- mem_we_i  in  1  MEM stage writes rd
- mem_wa_i  in  5  MEM destination
- mem_res_i  in  32  MEM writeback data
- valid_o  out  1  stage register holds a live instruction
- ready_i  in  1  EX accepts
- pc_o, instr_o  out  32 each  registered PC/instruction
- rs1_o, rs2_o  out  32 each  forwarded operands
- imm_o  out  32  extended immediate
- alu_code_o  out  4  ALU code
- shamt_o  out  5  shift amount
- srcb_sel_o, res_sel_o, branch_src_o, rf_src_o  out  1 each  control bits as produced by nf_control_unit
- we_rf_o, we_dm_o  out  1 each  write enables
- size_dm_o  out  2  load/store size
- branch_type_o  out  4  branch type
- wa3_o  out  5  destination register
- ill_o  out  1  illegal instruction
- stall_cnt_o  out  STALL_CNT_W  hazard stall cycles

Behaviour:
- **Reset** (resetn=0 at a clk edge): valid_o=0, every registered output 0, stall_cnt_o=0. Reset mid-stall or mid-hold discards the held instruction.
- **Latency:** 1 cycle. An instruction accepted at edge N appears on the outputs after edge N.
- **Operand usage:**
  - rs1_used = 0 for LUI, AUIPC, JAL; 1 otherwise.
  - rs2_used = 1 for R-type, STORE, BRANCH; 0 otherwise.
- **Hazard** (combinational): valid_i & ex_load_i & ex_we_i & ex_wa_i≠0 & ((rs1_used & ex_wa_i==ra1_o) | (rs2_used & ex_wa_i==ra2_o)).
  - When FWD_EN=0, the hazard additionally covers any match with a valid non-zero EX or MEM writer.
- **ready_o** = (~valid_o | ready_i) & ~hazard & ~flush_i.
- **Stage register update:**
  - Accept (valid_i & ready_o): load decoded bundle, valid_o=1.
  - Else if (~valid_o | ready_i): valid_o=0 (bubble). Data fields may update but must be ignored downstream.
  - Else (valid_o & ~ready_i): hold every output bit-stable.
- **flush_i** has priority over everything except reset. Next cycle valid_o=0 and no accept happens.
- **Forwarding** (FWD_EN=1), evaluated per operand:
  - address 0 → 0;
  - else EX match (ex_we_i & ~ex_load_i) → ex_res_i;
  - else MEM match (mem_we_i) → mem_res_i;
  - else rd1_i/rd2_i.
  - EX has priority over MEM when both match.
- **Illegal** (ILL_CHECK=1): instr_i[1:0]≠2'b11, or opcode not among LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Registers ill_o=1 and forces we_rf_o=0, we_dm_o=0, branch_type_o=0.
  - The instruction still passes with valid_o=1.
  - ILL_CHECK=0: ill_o tied 0.
- **Stall counter:** increments once per cycle in which valid_i & hazard & ~flush_i. Saturates at all-ones and does not wrap.
- **wa3_o:** 0 whenever we_rf_o=0.

Test Plan:
- **Basic accept:** reset, then valid_i=1, instr_i=0x00500093 (addi x1,x0,5), pc_i=0x100, ready_i=1 → next cycle valid_o=1, imm_o=5, wa3_o=1, we_rf_o=1, rs1_o=0, pc_o=0x100.
- **Back-pressure:** valid_o=1, ready_i=0 held 3 cycles while instr_i changes → outputs bit-stable, ready_o=0. Release ready_i → new instruction appears the following cycle.
- **Forwarding priority:**
  - EX writes x5 with 0xAAAA and MEM writes x5 with 0xBBBB; decode add x6,x5,x5 → rs1_o=rs2_o=0xAAAA.
  - EX inactive → both 0xBBBB.
  - Source x0 → 0 regardless.
- **Load-use:** EX load to x7; decode sw x7,0(x2) → ready_o=0, bubble (valid_o=0) one cycle, stall_cnt_o=1. EX advances → store accepted.
- **Flush:** flush_i=1 with valid_i=1 and valid_o=1 → next cycle valid_o=0, nothing accepted.
- **Illegal and saturation:**
  - instr_i=0x00000000 → ill_o=1, we_rf_o=0, we_dm_o=0, valid_o=1.
  - Stall counter with STALL_CNT_W=2 → after 5 hazard cycles stays 3.

Source files
------------

// File: rtl/nf_i_du_pl.sv
// nf_i_du_pl: pipelined RV32I decode stage with operand forwarding, load-use stall and ID/EX register
module nf_i_du_pl #(
  parameter int FWD_EN      = 1,
  parameter int ILL_CHECK   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [31:0]            instr_i,
  input  logic [31:0]            pc_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  output logic [4:0]             ra1_o,
  output logic [4:0]             ra2_o,
  input  logic [31:0]            rd1_i,
  input  logic [31:0]            rd2_i,
  input  logic                   ex_we_i,
  input  logic                   ex_load_i,
  input  logic [4:0]             ex_wa_i,
  input  logic [31:0]            ex_res_i,
  input  logic                   mem_we_i,
  input  logic [4:0]             mem_wa_i,
  input  logic [31:0]            mem_res_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            instr_o,
  output logic [31:0]            rs1_o,
  output logic [31:0]            rs2_o,
  output logic [31:0]            imm_o,
  output logic [3:0]             alu_code_o,
  output logic [4:0]             shamt_o,
  output logic                   srcb_sel_o,
  output logic                   res_sel_o,
  output logic                   branch_src_o,
  output logic                   rf_src_o,
  output logic                   we_rf_o,
  output logic                   we_dm_o,
  output logic [1:0]             size_dm_o,
  output logic [3:0]             branch_type_o,
  output logic [4:0]             wa3_o,
  output logic                   ill_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011;
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic ill, rs1_used, rs2_used, ex_m1, ex_m2, mem_m1, mem_m2, hazard, accept, we_rf, we_dm;
  logic [31:0] imm, rs1, rs2;
  logic [3:0] alu_code, branch_type;
  logic [1:0] size_dm;
  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign ra1_o    = instr_i[19:15];
  assign ra2_o    = instr_i[24:20];
  assign is_lui   = opc == LUI;
  assign is_auipc = opc == AUIPC;
  assign is_jal   = opc == JAL;
  assign is_jalr  = opc == JALR;
  assign is_br    = opc == BRANCH;
  assign is_ld    = opc == LOAD;
  assign is_st    = opc == STORE;
  assign is_opi   = opc == OPIMM;
  assign is_op    = opc == OP;
  assign ill      = (ILL_CHECK != 0) && (instr_i[1:0] != 2'b11 ||
                    !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st || is_opi || is_op));
  assign rs1_used = !(is_lui || is_auipc || is_jal);
  assign rs2_used = is_op || is_st || is_br;
  assign ex_m1    = ex_we_i && ex_wa_i != 5'd0 && ex_wa_i == ra1_o;
  assign ex_m2    = ex_we_i && ex_wa_i != 5'd0 && ex_wa_i == ra2_o;
  assign mem_m1   = mem_we_i && mem_wa_i != 5'd0 && mem_wa_i == ra1_o;
  assign mem_m2   = mem_we_i && mem_wa_i != 5'd0 && mem_wa_i == ra2_o;
  assign hazard   = valid_i && (
                    (rs1_used && ((ex_m1 && (ex_load_i || FWD_EN == 0)) || (mem_m1 && FWD_EN == 0))) ||
                    (rs2_used && ((ex_m2 && (ex_load_i || FWD_EN == 0)) || (mem_m2 && FWD_EN == 0))));
  assign ready_o  = (!valid_o || ready_i) && !hazard && !flush_i;
  assign accept   = valid_i && ready_o;
  always_comb begin
    imm = is_st ? {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]} :
          is_br ? {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
          (is_lui || is_auipc) ? {instr_i[31:12], 12'h000} :
          is_jal ? {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
          {{20{instr_i[31]}}, instr_i[31:20]};
    alu_code = is_op ? {instr_i[30], f3} : is_opi ? {f3 == 3'b101 && instr_i[30], f3} : is_br ? 4'b1000 : 4'b0000;
    size_dm = (is_ld || is_st) ? f3[1:0] : 2'b00;
    branch_type = ill ? 4'b0000 : is_br ? {1'b1, f3} : is_jal ? 4'b0001 : is_jalr ? 4'b0010 : 4'b0000;
    we_rf = !ill && (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op);
    we_dm = !ill && is_st;
    rs1 = FWD_EN == 0 ? rd1_i : ra1_o == 5'd0 ? 32'd0 : (ex_m1 && !ex_load_i) ? ex_res_i : mem_m1 ? mem_res_i : rd1_i;
    rs2 = FWD_EN == 0 ? rd2_i : ra2_o == 5'd0 ? 32'd0 : (ex_m2 && !ex_load_i) ? ex_res_i : mem_m2 ? mem_res_i : rd2_i;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_o       <= 1'b0;
      pc_o          <= '0;
      instr_o       <= '0;
      rs1_o         <= '0;
      rs2_o         <= '0;
      imm_o         <= '0;
      alu_code_o    <= '0;
      shamt_o       <= '0;
      srcb_sel_o    <= 1'b0;
      res_sel_o     <= 1'b0;
      branch_src_o  <= 1'b0;
      rf_src_o      <= 1'b0;
      we_rf_o       <= 1'b0;
      we_dm_o       <= 1'b0;
      size_dm_o     <= '0;
      branch_type_o <= '0;
      wa3_o         <= '0;
      ill_o         <= 1'b0;
    end else begin
      valid_o <= flush_i ? 1'b0 : accept ? 1'b1 : ready_i ? 1'b0 : valid_o;
      if (accept) begin
        pc_o          <= pc_i;
        instr_o       <= instr_i;
        rs1_o         <= rs1;
        rs2_o         <= rs2;
        imm_o         <= imm;
        alu_code_o    <= alu_code;
        shamt_o       <= instr_i[24:20];
        srcb_sel_o    <= !(is_op || is_br);
        res_sel_o     <= is_ld;
        branch_src_o  <= is_jalr;
        rf_src_o      <= is_jal || is_jalr;
        we_rf_o       <= we_rf;
        we_dm_o       <= we_dm;
        size_dm_o     <= size_dm;
        branch_type_o <= branch_type;
        wa3_o         <= we_rf ? instr_i[11:7] : 5'd0;
        ill_o         <= ill;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn)
      stall_cnt_o <= '0;
    else if (hazard && !flush_i && !(&stall_cnt_o))
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end
endmodule

// File: tb/tb_nf_i_du_pl.sv
// tb_nf_i_du_pl: scoreboard bench with directed scenarios and randomized traffic against a decode model
module tb_nf_i_du_pl;
  localparam int SW = 2;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011, LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011, OP = 7'b0110011;
  typedef struct packed {
    logic [31:0] pc, instr, rs1, rs2, imm;
    logic [3:0] alu;
    logic [4:0] shamt;
    logic srcb, ress, bsrc, rfsrc, werf, wedm;
    logic [1:0] size;
    logic [3:0] btype;
    logic [4:0] wa3;
    logic ill;
  } exp_t;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] instr_i, pc_i, rd1_i, rd2_i, ex_res_i, mem_res_i;
  logic valid_i, flush_i, ex_we_i, ex_load_i, mem_we_i, ready_i;
  logic [4:0] ex_wa_i, mem_wa_i, ra1_o, ra2_o;
  logic ready_o, valid_o, srcb_sel_o, res_sel_o, branch_src_o, rf_src_o, we_rf_o, we_dm_o, ill_o;
  logic [31:0] pc_o, instr_o, rs1_o, rs2_o, imm_o;
  logic [3:0] alu_code_o, branch_type_o;
  logic [4:0] shamt_o, wa3_o;
  logic [1:0] size_dm_o;
  logic [SW-1:0] stall_cnt_o;
  logic [31:0] rf [32];
  exp_t q[$];
  logic mv = 1'b0, zchk = 1'b0;
  int mcnt = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign rd1_i = rf[ra1_o];
  assign rd2_i = rf[ra2_o];
  nf_i_du_pl #(.FWD_EN(1), .ILL_CHECK(1), .STALL_CNT_W(SW)) dut (
    .clk(clk), .resetn(resetn), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .ra1_o(ra1_o), .ra2_o(ra2_o), .rd1_i(rd1_i), .rd2_i(rd2_i), .ex_we_i(ex_we_i),
    .ex_load_i(ex_load_i), .ex_wa_i(ex_wa_i), .ex_res_i(ex_res_i), .mem_we_i(mem_we_i), .mem_wa_i(mem_wa_i),
    .mem_res_i(mem_res_i), .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .alu_code_o(alu_code_o), .shamt_o(shamt_o),
    .srcb_sel_o(srcb_sel_o), .res_sel_o(res_sel_o), .branch_src_o(branch_src_o), .rf_src_o(rf_src_o),
    .we_rf_o(we_rf_o), .we_dm_o(we_dm_o), .size_dm_o(size_dm_o), .branch_type_o(branch_type_o),
    .wa3_o(wa3_o), .ill_o(ill_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [31:0] fw(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (ex_we_i && !ex_load_i && ex_wa_i == r) return ex_res_i;
    if (mem_we_i && mem_wa_i == r) return mem_res_i;
    return rf[r];
  endfunction
  function automatic logic haz_m();
    logic [6:0] op = instr_i[6:0];
    logic u1 = !(op inside {LUI, AUIPC, JAL});
    logic u2 = op inside {OP, STORE, BRANCH};
    return valid_i && ex_load_i && ex_we_i && ex_wa_i != 5'd0 &&
           ((u1 && ex_wa_i == instr_i[19:15]) || (u2 && ex_wa_i == instr_i[24:20]));
  endfunction
  function automatic exp_t model();
    exp_t e = '0;
    logic [31:0] i = instr_i;
    e.pc = pc_i; e.instr = i; e.rs1 = fw(i[19:15]); e.rs2 = fw(i[24:20]); e.shamt = i[24:20];
    e.imm = {{20{i[31]}}, i[31:20]};
    e.srcb = 1'b1;
    case (i[6:0])
      LUI, AUIPC: begin e.imm = {i[31:12], 12'h000}; e.werf = 1'b1; end
      JAL: begin
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.werf = 1'b1; e.rfsrc = 1'b1; e.btype = 4'd1;
      end
      JALR: begin e.werf = 1'b1; e.rfsrc = 1'b1; e.bsrc = 1'b1; e.btype = 4'd2; end
      BRANCH: begin
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.srcb = 1'b0; e.alu = 4'b1000; e.btype = {1'b1, i[14:12]};
      end
      LOAD: begin e.werf = 1'b1; e.ress = 1'b1; e.size = i[13:12]; end
      STORE: begin e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.wedm = 1'b1; e.size = i[13:12]; end
      OPIMM: begin e.werf = 1'b1; e.alu = {i[14:12] == 3'b101 && i[30], i[14:12]}; end
      OP: begin e.werf = 1'b1; e.srcb = 1'b0; e.alu = {i[30], i[14:12]}; end
      default: e.ill = 1'b1;
    endcase
    e.wa3 = e.werf ? i[11:7] : 5'd0;
    return e;
  endfunction
  function automatic logic [31:0] ctrl_e(input exp_t e);
    return 32'({e.alu, e.shamt, e.srcb, e.ress, e.bsrc, e.rfsrc, e.werf, e.wedm, e.size, e.btype, e.wa3, e.ill});
  endfunction
  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [9] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 10);
    if (k == 9) return w;
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if (k == 10) w[1:0] = 2'($urandom_range(0, 2));
    else w[6:0] = ops[k];
    return w;
  endfunction
  always @(posedge clk) begin
    logic acc;
    if (!resetn) begin
      q.delete();
      mv = 1'b0; mcnt = 0; zchk = 1'b1;
    end else begin
      acc = valid_i && (!mv || ready_i) && !haz_m() && !flush_i;
      if (acc) q.push_back(model());
      if (haz_m() && !flush_i && mcnt < (1 << SW) - 1) mcnt++;
      mv = flush_i ? 1'b0 : acc ? 1'b1 : ready_i ? 1'b0 : mv;
      zchk = 1'b0;
    end
  end
  always @(negedge clk) begin
    chk("valid_o", 32'(valid_o), 32'(mv));
    chk("stall_cnt", 32'(stall_cnt_o), 32'(mcnt));
    chk("ready_o", 32'(ready_o), 32'((!mv || ready_i) && !haz_m() && !flush_i));
    if (zchk)
      chk("reset_zero", 32'(|{pc_o, instr_o, rs1_o, rs2_o, imm_o, alu_code_o, shamt_o, srcb_sel_o, res_sel_o,
          branch_src_o, rf_src_o, we_rf_o, we_dm_o, size_dm_o, branch_type_o, wa3_o, ill_o}), 32'd0);
    if (mv) begin
      if (q.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
      else begin
        chk("pc_o", pc_o, q[0].pc);
        chk("instr_o", instr_o, q[0].instr);
        chk("rs1_o", rs1_o, q[0].rs1);
        chk("rs2_o", rs2_o, q[0].rs2);
        chk("imm_o", imm_o, q[0].imm);
        chk("ctrl", 32'({alu_code_o, shamt_o, srcb_sel_o, res_sel_o, branch_src_o, rf_src_o, we_rf_o, we_dm_o,
            size_dm_o, branch_type_o, wa3_o, ill_o}), ctrl_e(q[0]));
        if (ready_i || flush_i) void'(q.pop_front());
      end
    end
  end
  task automatic idle();
    valid_i = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0; ready_i = 1'b1;
    ex_we_i = 1'b0; ex_load_i = 1'b0; ex_wa_i = '0; ex_res_i = '0;
    mem_we_i = 1'b0; mem_wa_i = '0; mem_res_i = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int r = 0; r < 32; r++) rf[r] = r == 0 ? 32'd0 : $urandom;
    idle();
    repeat (2) tick();
    resetn = 1'b1;
    valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100; tick();
    valid_i = 1'b0; tick();
    valid_i = 1'b1; instr_i = 32'h00a00113; pc_i = 32'h104; tick();
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin instr_i = rnd_instr(); pc_i = $urandom; tick(); end
    ready_i = 1'b1; instr_i = 32'h00300193; pc_i = 32'h108; tick();
    valid_i = 1'b0; tick();
    ex_we_i = 1'b1; ex_wa_i = 5'd5; ex_res_i = 32'hAAAA; mem_we_i = 1'b1; mem_wa_i = 5'd5; mem_res_i = 32'hBBBB;
    valid_i = 1'b1; instr_i = 32'h00528333; tick();
    ex_we_i = 1'b0; tick();
    ex_we_i = 1'b1; instr_i = 32'h00000333; tick();
    idle(); tick();
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_wa_i = 5'd7; valid_i = 1'b1; instr_i = 32'h00712023; tick();
    ex_we_i = 1'b0; ex_load_i = 1'b0; tick();
    valid_i = 1'b0; tick();
    valid_i = 1'b1; instr_i = 32'h00500093; tick();
    flush_i = 1'b1; ready_i = 1'b0; tick();
    idle(); tick();
    valid_i = 1'b1; instr_i = 32'h00000000; tick();
    valid_i = 1'b0; tick();
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_wa_i = 5'd7; valid_i = 1'b1; instr_i = 32'h00712023;
    repeat (5) tick();
    idle(); tick();
    chk("stall_sat", 32'(stall_cnt_o), 32'd3);
    for (int c = 0; c < 4000; c++) begin
      resetn = $urandom_range(0, 299) != 0;
      valid_i = $urandom_range(0, 4) != 0;
      instr_i = rnd_instr(); pc_i = $urandom;
      flush_i = $urandom_range(0, 19) == 0;
      ready_i = $urandom_range(0, 3) != 0;
      ex_we_i = $urandom_range(0, 1) != 0; ex_load_i = $urandom_range(0, 2) == 0;
      ex_wa_i = 5'($urandom_range(0, 7)); ex_res_i = $urandom;
      mem_we_i = $urandom_range(0, 1) != 0; mem_wa_i = 5'($urandom_range(0, 7)); mem_res_i = $urandom;
      tick();
    end
    idle(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
